// File: rtl/pattern_scan_pkg.sv
// Shared types and constants for the pattern scan engine.
package pattern_scan_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SCAN  = 2'd2,
    S_DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/pattern_scan_engine_byte_window_match.sv
// Combinational matcher for one byte: in-byte windows plus windows that
// reach back into the bits retained from the previous byte.
module byte_window_match
  import pattern_scan_pkg::*;
#(
  parameter int PAT_W = 5
) (
  input  logic [BYTE_W-1:0] cur_byte,
  input  logic [BYTE_W-1:0] ret_bits,
  input  logic              first,
  input  logic [PAT_W-1:0]  pat,
  output logic [3:0]        in_cnt,
  output logic              any_match,
  output logic [3:0]        cross_cnt
);
  logic [2*BYTE_W-1:0] cat;

  assign cat = {ret_bits, cur_byte};

  // Window s ends at bit s of the current byte; s above BYTE_W-PAT_W reaches
  // into the previous byte, which does not exist for the first byte.
  always_comb begin
    in_cnt    = '0;
    cross_cnt = '0;
    for (int s = 0; s < BYTE_W; s++) begin
      if (cat[s +: PAT_W] == pat) begin
        if (s <= BYTE_W - PAT_W) begin
          in_cnt    = in_cnt + 4'd1;
          cross_cnt = cross_cnt + 4'd1;
        end else if (!first) begin
          cross_cnt = cross_cnt + 4'd1;
        end
      end
    end
    any_match = (in_cnt != 4'd0);
  end
endmodule

// File: rtl/pattern_scan_engine.sv
// Scans len bytes from memory as one bit string and counts occurrences of a
// PAT_W-bit pattern: inside bytes, per byte, and across byte boundaries.
module pattern_scan_engine
  import pattern_scan_pkg::*;
#(
  parameter int PAT_W     = 5,
  parameter int MAX_BYTES = 32,
  parameter int ADDR_W    = 8,
  localparam int CNT_W    = $clog2(8 * MAX_BYTES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [PAT_W-1:0]  pat,
  input  logic [ADDR_W-1:0] base,
  input  logic [7:0]        len,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  cnt_in,
  output logic [CNT_W-1:0]  cnt_bytes,
  output logic [CNT_W-1:0]  cnt_cross
);
  localparam logic [7:0]        MAX_LEN  = 8'(MAX_BYTES);
  localparam logic [BYTE_W-1:0] RET_MASK = BYTE_W'((1 << (PAT_W - 1)) - 1);

  // Protocol: req is accepted only while not busy (IDLE or DONE) and samples
  // pat/base/len on that edge; done stays high with stable counts until the
  // next accepted req. Read data returns one cycle after mem_addr.
  state_e              state_q, state_d;
  logic [PAT_W-1:0]    pat_q, pat_d;
  logic [ADDR_W-1:0]   base_q, base_d, addr_q, addr_d;
  logic [7:0]          len_q, len_d, k_q, k_d, len_clamp;
  logic [BYTE_W-1:0]   ret_q, ret_d;
  logic [CNT_W-1:0]    in_q, in_d, bytes_q, bytes_d, cross_q, cross_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                first_byte, m_any;
  logic [3:0]          m_in, m_cross;

  assign len_clamp  = (len > MAX_LEN) ? MAX_LEN : len;
  assign first_byte = (k_q == 8'd0);

  byte_window_match #(.PAT_W(PAT_W)) u_match (
    .cur_byte  (mem_rdata),
    .ret_bits  (ret_q),
    .first     (first_byte),
    .pat       (pat_q),
    .in_cnt    (m_in),
    .any_match (m_any),
    .cross_cnt (m_cross)
  );

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    base_d  = base_q;
    addr_d  = addr_q;
    len_d   = len_q;
    k_d     = k_q;
    ret_d   = ret_q;
    in_d    = in_q;
    bytes_d = bytes_q;
    cross_d = cross_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (req) begin
          pat_d   = pat;
          base_d  = base;
          len_d   = len_clamp;
          k_d     = 8'd0;
          ret_d   = '0;
          in_d    = '0;
          bytes_d = '0;
          cross_d = '0;
          if (len_clamp == 8'd0) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            addr_d  = '0;
          end else begin
            state_d = S_FETCH;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            addr_d  = base;
          end
        end
      end
      S_FETCH: begin
        state_d = S_SCAN;
        addr_d  = base_q + ADDR_W'(1);
      end
      S_SCAN: begin
        in_d    = in_q + CNT_W'(m_in);
        bytes_d = bytes_q + CNT_W'(m_any);
        cross_d = cross_q + CNT_W'(m_cross);
        ret_d   = mem_rdata & RET_MASK;
        if (k_q == len_q - 8'd1) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          addr_d  = '0;
        end else begin
          k_d    = k_q + 8'd1;
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      k_q     <= '0;
      ret_q   <= '0;
      in_q    <= '0;
      bytes_q <= '0;
      cross_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      k_q     <= k_d;
      ret_q   <= ret_d;
      in_q    <= in_d;
      bytes_q <= bytes_d;
      cross_q <= cross_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign mem_addr  = addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cnt_in    = in_q;
  assign cnt_bytes = bytes_q;
  assign cnt_cross = cross_q;
endmodule

// File: tb/tb_pattern_scan_engine.sv
// Bench for pattern_scan_engine: a PAT_W=5 and a PAT_W=3 instance, each with
// a synchronous-read memory, checked against a bit-string model.
module tb_pattern_scan_engine;
  localparam int CW = 9;
  localparam int W  = 3 * CW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       req_a, req_b;
  logic [4:0] pat_a;
  logic [2:0] pat_b;
  logic [7:0] base_a, base_b, len_a, len_b, addr_a, addr_b, rdata_a, rdata_b;
  logic       busy_a, busy_b, done_a, done_b;
  logic [CW-1:0] in_a, by_a, cr_a, in_b, by_b, cr_b;
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];

  pattern_scan_engine #(.PAT_W(5), .MAX_BYTES(32), .ADDR_W(8)) dut_a (
    .clk(clk), .reset(rst_n), .req(req_a), .pat(pat_a), .base(base_a), .len(len_a),
    .mem_addr(addr_a), .mem_rdata(rdata_a), .busy(busy_a), .done(done_a),
    .cnt_in(in_a), .cnt_bytes(by_a), .cnt_cross(cr_a));

  pattern_scan_engine #(.PAT_W(3), .MAX_BYTES(32), .ADDR_W(8)) dut_b (
    .clk(clk), .reset(rst_n), .req(req_b), .pat(pat_b), .base(base_b), .len(len_b),
    .mem_addr(addr_b), .mem_rdata(rdata_b), .busy(busy_b), .done(done_b),
    .cnt_in(in_b), .cnt_bytes(by_b), .cnt_cross(cr_b));

  always @(posedge clk) begin
    rdata_a <= mem_a[addr_a];
    rdata_b <= mem_b[addr_b];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  function automatic logic [W-1:0] model(input int which, input int pat, input int pw,
                                         input int base, input int len);
    int el, cin, cby, ccr, v, mask;
    bit hit;
    bit bq[$];
    logic [7:0] b;
    el = (len > 32) ? 32 : len;
    cin = 0; cby = 0; ccr = 0;
    mask = (1 << pw) - 1;
    for (int i = 0; i < el; i++) begin
      b = (which == 0) ? mem_a[(base + i) % 256] : mem_b[(base + i) % 256];
      hit = 0;
      for (int s = 0; s <= 8 - pw; s++)
        if (((int'(b) >> s) & mask) == pat) begin
          cin++;
          hit = 1;
        end
      if (hit) cby++;
      for (int j = 7; j >= 0; j--) bq.push_back(b[j]);
    end
    for (int p = 0; p + pw <= bq.size(); p++) begin
      v = 0;
      for (int t = 0; t < pw; t++) v = v * 2 + int'(bq[p + t]);
      if (v == pat) ccr++;
    end
    return {CW'(cin), CW'(cby), CW'(ccr)};
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q_a[$];
  logic [W-1:0] exp_q_b[$];
  logic [W-1:0] cur_a, cur_b;
  bit have_a = 0, have_b = 0, done_prev_a = 0, done_prev_b = 0;
  logic req_seen_a, req_seen_b;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_seen_a <= 1'b0;
      req_seen_b <= 1'b0;
    end else begin
      req_seen_a <= req_a && !busy_a;
      req_seen_b <= req_b && !busy_b;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      have_a = 0;
      have_b = 0;
    end else begin
      if (done_a && (!done_prev_a || req_seen_a)) begin
        if (exp_q_a.size() == 0) begin
          check("unexpected_done_a", 1, 0);
          have_a = 0;
        end else begin
          cur_a  = exp_q_a.pop_front();
          have_a = 1;
        end
      end
      if (done_a && have_a) begin
        check("cnt_in_a", int'(in_a), int'(cur_a[3*CW-1:2*CW]));
        check("cnt_bytes_a", int'(by_a), int'(cur_a[2*CW-1:CW]));
        check("cnt_cross_a", int'(cr_a), int'(cur_a[CW-1:0]));
      end
      if (done_b && (!done_prev_b || req_seen_b)) begin
        if (exp_q_b.size() == 0) begin
          check("unexpected_done_b", 1, 0);
          have_b = 0;
        end else begin
          cur_b  = exp_q_b.pop_front();
          have_b = 1;
        end
      end
      if (done_b && have_b) begin
        check("cnt_in_b", int'(in_b), int'(cur_b[3*CW-1:2*CW]));
        check("cnt_bytes_b", int'(by_b), int'(cur_b[2*CW-1:CW]));
        check("cnt_cross_b", int'(cr_b), int'(cur_b[CW-1:0]));
      end
    end
    done_prev_a = done_a;
    done_prev_b = done_b;
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int which, input bit r, input int p, input int b, input int l);
    if (which == 0) begin
      req_a = r; pat_a = 5'(p); base_a = 8'(b); len_a = 8'(l);
    end else begin
      req_b = r; pat_b = 3'(p); base_b = 8'(b); len_b = 8'(l);
    end
  endtask

  task automatic get_out(input int which, output int bsy, output int dn, output int ad,
                         output int ci, output int cb, output int cc);
    if (which == 0) begin
      bsy = int'(busy_a); dn = int'(done_a); ad = int'(addr_a);
      ci = int'(in_a); cb = int'(by_a); cc = int'(cr_a);
    end else begin
      bsy = int'(busy_b); dn = int'(done_b); ad = int'(addr_b);
      ci = int'(in_b); cb = int'(by_b); cc = int'(cr_b);
    end
  endtask

  task automatic check_cleared(input string tag, input int which);
    int bsy, dn, ad, ci, cb, cc;
    get_out(which, bsy, dn, ad, ci, cb, cc);
    check({tag, "_busy"}, bsy, 0);
    check({tag, "_done"}, dn, 0);
    check({tag, "_addr"}, ad, 0);
    check({tag, "_cnt_in"}, ci, 0);
    check({tag, "_cnt_bytes"}, cb, 0);
    check({tag, "_cnt_cross"}, cc, 0);
  endtask

  // abort_n: assert reset at the negedge after that edge; busy_req_n: edge of a stray req.
  task automatic run(input int which, input int pat, input int base, input int len,
                     input int abort_n, input int busy_req_n, output int done_edge);
    int el, pw, bsy, dn, ad, ci, cb, cc;
    bit exp_busy;
    string sfx;
    el  = (len > 32) ? 32 : len;
    pw  = (which == 0) ? 5 : 3;
    sfx = (which == 0) ? "a" : "b";
    done_edge = -1;
    if (abort_n < 0) begin
      if (which == 0) exp_q_a.push_back(model(which, pat, pw, base, len));
      else            exp_q_b.push_back(model(which, pat, pw, base, len));
    end
    @(negedge clk);
    drive(which, 1, pat, base, len);
    for (int n = 0; n <= el + 1; n++) begin
      @(negedge clk);
      drive(which, (n == busy_req_n - 1), $urandom_range(0, 31), $urandom_range(0, 255),
            $urandom_range(0, 40));
      get_out(which, bsy, dn, ad, ci, cb, cc);
      exp_busy = (el > 0) && (n <= el);
      check($sformatf("busy_%s_e%0d", sfx, n), bsy, int'(exp_busy));
      check($sformatf("done_%s_e%0d", sfx, n), dn, int'((el == 0) || (n >= el + 1)));
      check($sformatf("addr_%s_e%0d", sfx, n), ad, exp_busy ? ((base + n) % 256) : 0);
      if (n == 0) begin
        check({"start_clear_in_", sfx}, ci, 0);
        check({"start_clear_cross_", sfx}, cc, 0);
      end
      if (dn != 0 && done_edge < 0) done_edge = n + 1;
      if (n == abort_n) begin
        rst_n = 1'b0;
        #1;
        check_cleared({"abort_", sfx}, which);
        @(negedge clk);
        rst_n = 1'b1;
        drive(which, 0, 0, 0, 0);
        return;
      end
    end
    drive(which, 0, 0, 0, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] e;
    int de;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 8'($urandom_range(0, 255));
      mem_b[i] = 8'($urandom_range(0, 255));
    end
    for (int i = 0; i < 32; i++) mem_a[i] = 8'hAA;
    for (int i = 64; i < 96; i++) mem_a[i] = 8'h00;
    for (int i = 0; i < 4; i++) mem_b[i] = 8'hFF;

    repeat (2) @(negedge clk);
    check_cleared("reset_a", 0);
    check_cleared("reset_b", 1);
    rst_n = 1'b1;
    @(negedge clk);

    // 0xAA with pattern 10101
    e = model(0, 21, 5, 0, 32);
    check("model_aa_in", int'(e[3*CW-1:2*CW]), 64);
    check("model_aa_cross", int'(e[CW-1:0]), 126);
    run(0, 21, 0, 32, -1, -1, de);
    check("aa_done_edge", de, 34);
    @(negedge clk);
    check("aa_cnt_in", int'(in_a), 64);
    check("aa_cnt_bytes", int'(by_a), 32);
    check("aa_cnt_cross", int'(cr_a), 126);

    // all-zero bytes with pattern 00000, restarted from DONE
    e = model(0, 0, 5, 64, 32);
    check("model_zero_cross", int'(e[CW-1:0]), 252);
    run(0, 0, 64, 32, -1, -1, de);
    check("zero_done_edge", de, 34);
    check("zero_cnt_in", int'(in_a), 128);
    check("zero_cnt_bytes", int'(by_a), 32);
    check("zero_cnt_cross", int'(cr_a), 252);

    // PAT_W=3, pattern 111 over 0xFF
    run(1, 7, 0, 4, -1, -1, de);
    check("ff_done_edge", de, 6);
    check("ff_cnt_in", int'(in_b), 24);
    check("ff_cnt_bytes", int'(by_b), 4);
    check("ff_cnt_cross", int'(cr_b), 30);

    // len=0 goes straight to DONE
    run(0, 3, 200, 0, -1, -1, de);
    check("len0_done_edge", de, 1);
    check("len0_addr", int'(addr_a), 0);
    check("len0_cnt_cross", int'(cr_a), 0);

    // reset mid-scan at byte 10, then identical rerun
    run(0, 21, 0, 32, 11, -1, de);
    run(0, 21, 0, 32, -1, -1, de);
    check("rerun_done_edge", de, 34);
    check("rerun_cnt_in", int'(in_a), 64);
    check("rerun_cnt_bytes", int'(by_a), 32);
    check("rerun_cnt_cross", int'(cr_a), 126);

    // stray req at edge 5 of a busy scan
    run(0, $urandom_range(0, 31), 128, 20, -1, 5, de);
    check("busyreq_done_edge", de, 22);

    // len above MAX_BYTES clamps; addresses wrap past 255
    run(0, $urandom_range(0, 31), 250, 40, -1, -1, de);
    check("clamp_done_edge", de, 34);

    run(1, $urandom_range(0, 7), 10, 7, -1, -1, de);
    check("b_rand_done_edge", de, 9);

    repeat (2) @(negedge clk);
    check("exp_q_a_drained", exp_q_a.size(), 0);
    check("exp_q_b_drained", exp_q_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end
endmodule
